// File: rtl/pe_cfg_pkg.sv
// Shared definitions for the PE ID configuration engine: stream kind encodings,
// controller states and small arithmetic helpers used at elaboration/compare time.
package pe_cfg_pkg;

  localparam int CW = 8;

  typedef enum logic [2:0] {
    KIND_FY  = 3'd0,
    KIND_FX  = 3'd1,
    KIND_IY  = 3'd2,
    KIND_IX  = 3'd3,
    KIND_PSY = 3'd4,
    KIND_PSX = 3'd5,
    KIND_OPY = 3'd6,
    KIND_OPX = 3'd7
  } cfg_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_EMIT  = 3'd2,
    ST_FIN   = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic [31:0] ones_of(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Exact quotient n/d found by search; zero when d does not divide n.
  function automatic logic [CW-1:0] exact_quot(input int n, input logic [CW-1:0] d);
    logic [CW-1:0] q_v;
    q_v = '0;
    for (int q = 1; q <= 64; q++) begin
      if ((32'(d) * 32'(q)) == 32'(n)) begin
        q_v = CW'(q);
      end else begin
        q_v = q_v;
      end
    end
    return q_v;
  endfunction

endpackage

// File: rtl/pe_id_calc.sv
// Combinational ID value and address for one configuration word, derived from
// the kind, the row/column walk counters and the latched mapping parameters.
module pe_id_calc
  import pe_cfg_pkg::*;
#(
  parameter int ARRAY_H = 6,
  parameter int ARRAY_W = 8,
  parameter int XID_W   = 5,
  parameter int YID_W   = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 5
) (
  input  cfg_kind_e          kind,
  input  logic [CW-1:0]      row,
  input  logic [CW-1:0]      col,
  input  logic [CW-1:0]      ro,
  input  logic [CW-1:0]      yq,
  input  logic [CW-1:0]      lm,
  input  logic [CW-1:0]      lq,
  input  logic [CW-1:0]      kk,
  input  logic [CW-1:0]      g,
  input  logic [CW-1:0]      l_len,
  input  logic               linear,
  input  logic [2:0]         r,
  input  logic [2:0]         t,
  input  logic [1:0]         kernel_h,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  data
);

  logic [2:0]  kind_bits_s;
  logic [31:0] ones_x_s;
  logic [31:0] ones_y_s;
  logic        in_t_s;
  logic        ps_row_s;
  logic        op_row_s;
  logic [31:0] val_s;
  logic [31:0] val_m_s;
  logic [31:0] addr_s;

  assign kind_bits_s = kind;
  assign ones_x_s    = ones_of(XID_W);
  assign ones_y_s    = ones_of(YID_W);

  // Field value selection per kind; odd kinds are X fields, even kinds Y fields.
  always_comb begin
    in_t_s   = (col < {5'd0, t});
    ps_row_s = linear ? (row == 8'd0) : (lm == 8'd0);
    op_row_s = linear ? (row == 8'(ARRAY_H - 1)) : (lm == (l_len - 8'd1));
    val_s    = 32'd0;
    case (kind)
      KIND_FY:  val_s = linear ? 32'(row) : 32'(yq);
      KIND_FX:  val_s = linear ? (in_t_s ? 32'(col) : ones_x_s)
                               : (32'(ro) + (32'(g) * 32'(kernel_h)));
      KIND_IY:  val_s = linear ? 32'(row) : ((r > 3'd1) ? 32'(yq) : 32'd0);
      KIND_IX:  val_s = linear ? (in_t_s ? 32'd0 : ones_x_s) : (32'(ro) + 32'(kk));
      KIND_PSY: val_s = ps_row_s ? (linear ? 32'd0 : 32'(lq)) : ones_y_s;
      KIND_PSX: val_s = (ps_row_s && (in_t_s || !linear)) ? 32'(col) : ones_x_s;
      KIND_OPY: val_s = op_row_s ? (linear ? 32'd0 : 32'(lq)) : ones_y_s;
      KIND_OPX: val_s = (op_row_s && (in_t_s || !linear)) ? 32'(col) : ones_x_s;
      default:  val_s = 32'd0;
    endcase
    val_m_s = kind_bits_s[0] ? (val_s & ones_x_s) : (val_s & ones_y_s);
    addr_s  = kind_bits_s[0] ? ((32'(row) * 32'(ARRAY_W)) + 32'(col)) : 32'(row);
  end

  assign data = val_m_s[DATA_W-1:0];
  assign addr = addr_s[ADDR_W-1:0];

endmodule

// File: rtl/pe_id_config_engine.sv
// Streams per-PE X/Y ID configuration words for a PE array and publishes the
// partial-sum chain mask once a run completes.
module pe_id_config_engine
  import pe_cfg_pkg::*;
#(
  parameter int ARRAY_H = 6,
  parameter int ARRAY_W = 8,
  parameter int XID_W   = 5,
  parameter int YID_W   = 3,
  localparam int ADDR_W = $clog2(ARRAY_H * ARRAY_W),
  localparam int DATA_W = (XID_W > YID_W) ? XID_W : YID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                linear,
  input  logic [2:0]          e,
  input  logic [2:0]          r,
  input  logic [2:0]          t_h,
  input  logic [2:0]          t,
  input  logic [1:0]          kernel_h,
  output logic                cfg_valid,
  input  logic                cfg_ready,
  output logic [2:0]          cfg_kind,
  output logic [ADDR_W-1:0]   cfg_addr,
  output logic [DATA_W-1:0]   cfg_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ARRAY_H-2:0]  ln_chain
);

  state_e              state_r;
  logic                cfg_valid_r;
  cfg_kind_e           cfg_kind_r;
  logic [ADDR_W-1:0]   cfg_addr_r;
  logic [DATA_W-1:0]   cfg_data_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic [ARRAY_H-2:0]  ln_chain_r;

  logic                linear_r;
  logic [2:0]          e_r;
  logic [2:0]          r_r;
  logic [2:0]          t_h_r;
  logic [2:0]          t_r;
  logic [1:0]          kh_r;

  // Walk counters point at the word to be loaded next into the output registers.
  cfg_kind_e           kind_r, kind_n;
  logic [CW-1:0]       row_r, row_n, col_r, col_n;
  logic [CW-1:0]       ro_r, ro_n, yq_r, yq_n, lm_r, lm_n, lq_r, lq_n;
  logic [CW-1:0]       kk_r, kk_n, g_r, g_n;
  logic                ex_r, ex_n;

  logic [CW-1:0]       e8_s;
  logic [CW-1:0]       rt_s;
  logic [CW-1:0]       rb_s;
  logic [CW-1:0]       l_s;
  logic                bad_s;
  logic                start_acc_s;
  logic                load_s;
  logic [ADDR_W-1:0]   calc_addr_s;
  logic [DATA_W-1:0]   calc_data_s;
  logic [ARRAY_H-2:0]  ln_next_s;
  logic [CW-1:0]       lmod_s;

  assign e8_s        = {5'd0, e_r};
  assign rt_s        = {5'd0, r_r} * {5'd0, t_h_r};
  assign rb_s        = exact_quot(ARRAY_H, rt_s);
  assign l_s         = exact_quot(ARRAY_H, {5'd0, t_h_r});
  assign bad_s       = (e_r == 3'd0) || (kh_r == 2'd0) || (rt_s == 8'd0) || (rb_s == 8'd0) ||
                       (linear_r && ({5'd0, t_r} > 8'(ARRAY_W)));
  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign load_s      = ((state_r == ST_CHECK) && !abort && !bad_s) ||
                       ((state_r == ST_EMIT) && !abort && cfg_valid_r && cfg_ready && !ex_r);

  pe_id_calc #(
    .ARRAY_H (ARRAY_H),
    .ARRAY_W (ARRAY_W),
    .XID_W   (XID_W),
    .YID_W   (YID_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_calc (
    .kind     (kind_r),
    .row      (row_r),
    .col      (col_r),
    .ro       (ro_r),
    .yq       (yq_r),
    .lm       (lm_r),
    .lq       (lq_r),
    .kk       (kk_r),
    .g        (g_r),
    .l_len    (l_s),
    .linear   (linear_r),
    .r        (r_r),
    .t        (t_r),
    .kernel_h (kh_r),
    .addr     (calc_addr_s),
    .data     (calc_data_s)
  );

  // Next walk position; the mod/div terms ride along as wrapping counters.
  always_comb begin
    kind_n = kind_r;
    row_n  = row_r;
    col_n  = col_r;
    ro_n   = ro_r;
    yq_n   = yq_r;
    lm_n   = lm_r;
    lq_n   = lq_r;
    kk_n   = kk_r;
    g_n    = g_r;
    ex_n   = ex_r;
    if (kind_r[0] && (col_r != 8'(ARRAY_W - 1))) begin
      col_n = col_r + 8'd1;
      if (kk_r == (e8_s - 8'd1)) begin
        kk_n = 8'd0;
        g_n  = g_r + 8'd1;
      end else begin
        kk_n = kk_r + 8'd1;
      end
    end else begin
      col_n = 8'd0;
      kk_n  = 8'd0;
      g_n   = 8'd0;
      if (row_r != 8'(ARRAY_H - 1)) begin
        row_n = row_r + 8'd1;
        if (ro_r == (rb_s - 8'd1)) begin
          ro_n = 8'd0;
          yq_n = yq_r + 8'd1;
        end else begin
          ro_n = ro_r + 8'd1;
        end
        if (lm_r == (l_s - 8'd1)) begin
          lm_n = 8'd0;
          lq_n = lq_r + 8'd1;
        end else begin
          lm_n = lm_r + 8'd1;
        end
      end else begin
        row_n = 8'd0;
        ro_n  = 8'd0;
        yq_n  = 8'd0;
        lm_n  = 8'd0;
        lq_n  = 8'd0;
        if (kind_r == KIND_OPX) begin
          ex_n = 1'b1;
        end else begin
          kind_n = cfg_kind_e'(kind_r + 3'd1);
        end
      end
    end
  end

  // Chain mask: a link is broken at the last row of each group of L rows.
  always_comb begin
    ln_next_s = '0;
    lmod_s    = 8'd0;
    for (int i = 0; i < ARRAY_H - 1; i++) begin
      ln_next_s[i] = linear_r || (lmod_s != (l_s - 8'd1));
      lmod_s       = (lmod_s == (l_s - 8'd1)) ? 8'd0 : (lmod_s + 8'd1);
    end
  end

  // Walk counters: cleared on an accepted start, stepped on every word load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_r <= KIND_FY;
      row_r  <= 8'd0;
      col_r  <= 8'd0;
      ro_r   <= 8'd0;
      yq_r   <= 8'd0;
      lm_r   <= 8'd0;
      lq_r   <= 8'd0;
      kk_r   <= 8'd0;
      g_r    <= 8'd0;
      ex_r   <= 1'b0;
    end else if (start_acc_s) begin
      kind_r <= KIND_FY;
      row_r  <= 8'd0;
      col_r  <= 8'd0;
      ro_r   <= 8'd0;
      yq_r   <= 8'd0;
      lm_r   <= 8'd0;
      lq_r   <= 8'd0;
      kk_r   <= 8'd0;
      g_r    <= 8'd0;
      ex_r   <= 1'b0;
    end else if (load_s) begin
      kind_r <= kind_n;
      row_r  <= row_n;
      col_r  <= col_n;
      ro_r   <= ro_n;
      yq_r   <= yq_n;
      lm_r   <= lm_n;
      lq_r   <= lq_n;
      kk_r   <= kk_n;
      g_r    <= g_n;
      ex_r   <= ex_n;
    end
  end

  // Run controller with registered stream and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cfg_valid_r <= 1'b0;
      cfg_kind_r  <= KIND_FY;
      cfg_addr_r  <= '0;
      cfg_data_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      ln_chain_r  <= '1;
      linear_r    <= 1'b0;
      e_r         <= 3'd0;
      r_r         <= 3'd0;
      t_h_r       <= 3'd0;
      t_r         <= 3'd0;
      kh_r        <= 2'd0;
    end else begin
      done_r <= 1'b0;
      if (load_s) begin
        cfg_kind_r <= kind_r;
        cfg_addr_r <= calc_addr_s;
        cfg_data_r <= calc_data_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            linear_r <= linear;
            e_r      <= e;
            r_r      <= r;
            t_h_r    <= t_h;
            t_r      <= t;
            kh_r     <= kernel_h;
            err_r    <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (bad_s) begin
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_ERR;
          end else begin
            cfg_valid_r <= 1'b1;
            state_r     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          // Abort takes priority over a handshake in the same cycle.
          if (abort) begin
            cfg_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (cfg_valid_r && cfg_ready && ex_r) begin
            cfg_valid_r <= 1'b0;
            done_r      <= 1'b1;
            ln_chain_r  <= ln_next_s;
            state_r     <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_ERR: begin
          state_r <= ST_IDLE;
        end
        default: begin
          cfg_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_valid = cfg_valid_r;
  assign cfg_kind  = cfg_kind_r;
  assign cfg_addr  = cfg_addr_r;
  assign cfg_data  = cfg_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign ln_chain  = ln_chain_r;

endmodule

// File: tb/tb_pe_id_config_engine.sv
// Scoreboard bench for pe_id_config_engine: expected words are queued at start
// and popped by a monitor on every cfg handshake.
module tb_pe_id_config_engine;

  localparam int H = 6;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       linear = 1'b0;
  logic [2:0] e = 3'd0;
  logic [2:0] r = 3'd0;
  logic [2:0] t_h = 3'd0;
  logic [2:0] t = 3'd0;
  logic [1:0] kernel_h = 2'd0;
  logic       cfg_ready = 1'b1;
  logic       cfg_valid;
  logic [2:0] cfg_kind;
  logic [5:0] cfg_addr;
  logic [4:0] cfg_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] ln_chain;

  always #5 clk = ~clk;

  pe_id_config_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .linear    (linear),
    .e         (e),
    .r         (r),
    .t_h       (t_h),
    .t         (t),
    .kernel_h  (kernel_h),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_kind  (cfg_kind),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ln_chain  (ln_chain)
  );

  typedef struct packed {
    logic [2:0] kind;
    logic [5:0] addr;
    logic [4:0] data;
  } word_t;

  word_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         hs_cnt = 0;
  int         done_cnt = 0;
  bit         vseen = 1'b0;
  logic [4:0] cap [0:7][0:47];
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [2:0] pk = 3'd0;
  logic [5:0] pa = 6'd0;
  logic [4:0] pd = 5'd0;

  function automatic logic [4:0] model(input int kind, input int i, input int j, input int lin,
                                       input int ev, input int rv, input int th, input int tv,
                                       input int kh);
    int rb, ll, v;
    rb = H / (rv * th);
    ll = H / th;
    v = 0;
    if (lin != 0) begin
      case (kind)
        0: v = i;
        1: v = (j < tv) ? j : 31;
        2: v = i;
        3: v = (j < tv) ? 0 : 31;
        4: v = (i == 0) ? 0 : 7;
        5: v = (i == 0 && j < tv) ? j : 31;
        6: v = (i == H - 1) ? 0 : 7;
        default: v = (i == H - 1 && j < tv) ? j : 31;
      endcase
    end else begin
      case (kind)
        0: v = i / rb;
        1: v = (i % rb) + (j / ev) * kh;
        2: v = (rv > 1) ? i / rb : 0;
        3: v = (i % rb) + (j % ev);
        4: v = (i % ll == 0) ? i / ll : 7;
        5: v = (i % ll == 0) ? j : 31;
        6: v = (i % ll == ll - 1) ? i / ll : 7;
        default: v = (i % ll == ll - 1) ? j : 31;
      endcase
    end
    return (kind % 2 == 1) ? 5'(v & 31) : 5'(v & 7);
  endfunction

  task automatic push_exp(input int lin, input int ev, input int rv, input int th,
                          input int tv, input int kh);
    word_t w;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < H; i++) begin
        if (k % 2 == 0) begin
          w.kind = 3'(k);
          w.addr = 6'(i);
          w.data = model(k, i, 0, lin, ev, rv, th, tv, kh);
          exp_q.push_back(w);
        end else begin
          for (int j = 0; j < W; j++) begin
            w.kind = 3'(k);
            w.addr = 6'(i * W + j);
            w.data = model(k, i, j, lin, ev, rv, th, tv, kh);
            exp_q.push_back(w);
          end
        end
      end
    end
  endtask

  task automatic start_run(input int lin, input int ev, input int rv, input int th,
                           input int tv, input int kh, input bit push);
    @(posedge clk); #1;
    linear   = 1'(lin);
    e        = 3'(ev);
    r        = 3'(rv);
    t_h      = 3'(th);
    t        = 3'(tv);
    kernel_h = 2'(kh);
    start    = 1'b1;
    if (push) push_exp(lin, ev, rv, th, tv, kh);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input int start_at, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      cfg_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (c == start_at);
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    cfg_ready = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard monitor and hold-during-stall check, sampled on the falling edge.
  always @(negedge clk) begin : mon
    word_t w;
    if (rst_n) begin
      if (done) done_cnt++;
      if (cfg_valid) vseen = 1'b1;
      if (cfg_valid && pv && !pr) begin
        total++;
        if ({cfg_kind, cfg_addr, cfg_data} !== {pk, pa, pd}) begin
          bad++;
          $display("FAIL stall_hold got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   cfg_kind, cfg_addr, cfg_data, pk, pa, pd);
        end
      end
      if (cfg_valid && cfg_ready) begin
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_word got=%0d/%0d/%0d want=none", cfg_kind, cfg_addr, cfg_data);
        end else begin
          w = exp_q.pop_front();
          if ({cfg_kind, cfg_addr, cfg_data} !== {w.kind, w.addr, w.data}) begin
            bad++;
            $display("FAIL stream got=%0d/%0d/%0d want=%0d/%0d/%0d",
                     cfg_kind, cfg_addr, cfg_data, w.kind, w.addr, w.data);
          end
        end
        if (cfg_addr < 6'd48) cap[cfg_kind][cfg_addr] = cfg_data;
      end
    end
    pv = cfg_valid & rst_n;
    pr = cfg_ready;
    pk = cfg_kind;
    pa = cfg_addr;
    pd = cfg_data;
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({cfg_valid, busy, done, err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {cfg_valid, busy, done, err});
    end
    total++;
    if ({cfg_kind, cfg_addr, cfg_data} !== 14'd0) begin
      bad++;
      $display("FAIL reset_fields got=%0d/%0d/%0d want=0/0/0", cfg_kind, cfg_addr, cfg_data);
    end
    total++;
    if (ln_chain !== 5'b11111) begin
      bad++;
      $display("FAIL reset_ln got=%b want=11111", ln_chain);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({cfg_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_release got=%b want=00", {cfg_valid, busy});
    end
  endtask

  task automatic test_conv_basic;
    int base, d0;
    bit seen;
    base = hs_cnt;
    d0 = done_cnt;
    start_run(0, 4, 1, 2, 0, 3, 1'b1);
    @(negedge clk);
    total++;
    if ({cfg_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL check_cycle got=%b want=01", {cfg_valid, busy});
    end
    @(negedge clk);
    total++;
    if (cfg_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_valid_latency got=%b want=1", cfg_valid);
    end
    wait_done(600, 1'b0, -1, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL conv_done_timeout got=0 want=1"); end
    total++;
    if (hs_cnt - base != 216) begin
      bad++;
      $display("FAIL conv_word_count got=%0d want=216", hs_cnt - base);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL conv_done_once got=%0d want=1", done_cnt - d0);
    end
    total++;
    if ({cap[1][37], cap[3][37]} !== {5'd4, 5'd2}) begin
      bad++;
      $display("FAIL conv_r4c5 got=%0d/%0d want=4/2", cap[1][37], cap[3][37]);
    end
    total++;
    if ({cap[4][0], cap[4][3], cap[4][1]} !== {5'd0, 5'd1, 5'd7}) begin
      bad++;
      $display("FAIL conv_psy got=%0d/%0d/%0d want=0/1/7", cap[4][0], cap[4][3], cap[4][1]);
    end
    total++;
    if (ln_chain !== 5'b11011) begin
      bad++;
      $display("FAIL conv_ln got=%b want=11011", ln_chain);
    end
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL conv_idle busy=%b left=%0d want=0/0", busy, exp_q.size());
    end
  endtask

  task automatic test_conv_r2;
    bit seen;
    logic [4:0] fy_exp [0:5];
    fy_exp = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1};
    start_run(0, 2, 2, 1, 0, 3, 1'b1);
    wait_done(600, 1'b0, -1, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL r2_done_timeout got=0 want=1"); end
    for (int i = 0; i < H; i++) begin
      total++;
      if (cap[0][i] !== fy_exp[i]) begin
        bad++;
        $display("FAIL r2_fy row=%0d got=%0d want=%0d", i, cap[0][i], fy_exp[i]);
      end
    end
    for (int i = 0; i < H; i++) begin
      total++;
      if (cap[7][i * W + 2] !== ((i == 5) ? 5'd2 : 5'd31)) begin
        bad++;
        $display("FAIL r2_opx row=%0d got=%0d want=%0d", i, cap[7][i * W + 2],
                 (i == 5) ? 2 : 31);
      end
    end
    total++;
    if (ln_chain !== 5'b11111) begin
      bad++;
      $display("FAIL r2_ln got=%b want=11111", ln_chain);
    end
  endtask

  task automatic test_linear;
    bit seen;
    logic [4:0] fx_exp [0:7];
    logic [4:0] ix_exp [0:7];
    fx_exp = '{5'd0, 5'd1, 5'd2, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    ix_exp = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    start_run(1, 1, 1, 1, 3, 1, 1'b1);
    wait_done(600, 1'b0, -1, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL lin_done_timeout got=0 want=1"); end
    for (int j = 0; j < W; j++) begin
      total++;
      if ({cap[1][2 * W + j], cap[3][2 * W + j]} !== {fx_exp[j], ix_exp[j]}) begin
        bad++;
        $display("FAIL lin_row2 col=%0d got=%0d/%0d want=%0d/%0d", j, cap[1][2 * W + j],
                 cap[3][2 * W + j], fx_exp[j], ix_exp[j]);
      end
    end
    for (int i = 0; i < H; i++) begin
      total++;
      if (cap[6][i] !== ((i == 5) ? 5'd0 : 5'd7)) begin
        bad++;
        $display("FAIL lin_opy row=%0d got=%0d want=%0d", i, cap[6][i], (i == 5) ? 0 : 7);
      end
    end
  endtask

  task automatic test_random_ready;
    int base, d0;
    bit seen;
    base = hs_cnt;
    d0 = done_cnt;
    start_run(0, 4, 1, 2, 0, 3, 1'b1);
    wait_done(3000, 1'b1, 30, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL rnd_done_timeout got=0 want=1"); end
    total++;
    if (hs_cnt - base != 216 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_word_count got=%0d left=%0d want=216/0", hs_cnt - base, exp_q.size());
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL rnd_done_once got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_err;
    int d0;
    bit seen;
    d0 = done_cnt;
    vseen = 1'b0;
    start_run(0, 1, 4, 1, 0, 1, 1'b0);
    repeat (5) @(negedge clk);
    total++;
    if ({err, vseen, busy} !== 3'b100) begin
      bad++;
      $display("FAIL err_flag err/valid/busy got=%b want=100", {err, vseen, busy});
    end
    total++;
    if (done_cnt != d0) begin
      bad++;
      $display("FAIL err_no_done got=%0d want=0", done_cnt - d0);
    end
    start_run(0, 4, 1, 2, 0, 3, 1'b1);
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared got=%b want=0", err);
    end
    wait_done(600, 1'b0, -1, seen);
    total++;
    if (!seen || ln_chain !== 5'b11011) begin
      bad++;
      $display("FAIL err_rerun done=%b ln=%b want=1/11011", seen, ln_chain);
    end
  endtask

  task automatic test_abort;
    int base, d0;
    bit hit;
    base = hs_cnt;
    d0 = done_cnt;
    hit = 1'b0;
    start_run(0, 2, 2, 1, 0, 3, 1'b1);
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      if (hs_cnt - base >= 100) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL abort_reach got=%0d want=100", hs_cnt - base); end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    total++;
    if ({cfg_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL abort_drop got=%b want=00", {cfg_valid, busy});
    end
    total++;
    if (ln_chain !== 5'b11011) begin
      bad++;
      $display("FAIL abort_ln got=%b want=11011", ln_chain);
    end
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt != d0) begin
      bad++;
      $display("FAIL abort_no_done got=%0d want=0", done_cnt - d0);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int base;
    bit hit;
    base = hs_cnt;
    hit = 1'b0;
    start_run(0, 4, 1, 2, 0, 3, 1'b1);
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      if (hs_cnt - base >= 50) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rst_reach got=%0d want=50", hs_cnt - base); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cfg_valid, busy, done, err} !== 4'b0000 || {cfg_kind, cfg_data} !== 8'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%b/%0d/%0d want=0000/0/0",
               {cfg_valid, busy, done, err}, cfg_kind, cfg_data);
    end
    total++;
    if (ln_chain !== 5'b11111) begin
      bad++;
      $display("FAIL rst_mid_ln got=%b want=11111", ln_chain);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    vseen = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if ({vseen, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rst_no_resume got=%b want=00", {vseen, busy});
    end
  endtask

  initial begin
    test_reset();
    test_conv_basic();
    test_conv_r2();
    test_linear();
    test_random_ready();
    test_err();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
